// File: rtl/reg_bus_arbiter_pkg.sv
// rtl/reg_bus_arbiter_pkg.sv - shared types for the register bus arbiter
//
// Contents:
//   reg_bus_state_t : arbiter FSM states
//   rb_status_t     : 32-bit transaction status word layout
//   rb_make_status  : builds a status word from its fields
package reg_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_STROBE   = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_DONE     = 2'd3
    } reg_bus_state_t;

    // Bit 0 ok, bit 1 timeout, bit 2 RW, [6:4] winner, [15:8] address,
    // [31:16] transaction counter. Bits 3 and 7 read as zero.
    typedef struct packed {
        logic [15:0] txn_cnt;
        logic [7:0]  addr;
        logic        rsvd7;
        logic [2:0]  winner;
        logic        rsvd3;
        logic        rw;
        logic        timeout;
        logic        ok;
    } rb_status_t;

    function automatic rb_status_t rb_make_status(
        input logic        ok,
        input logic        timeout,
        input logic        rw,
        input logic [2:0]  winner,
        input logic [7:0]  addr,
        input logic [15:0] txn_cnt
    );
        rb_status_t s;
        s.txn_cnt = txn_cnt;
        s.addr    = addr;
        s.rsvd7   = 1'b0;
        s.winner  = winner;
        s.rsvd3   = 1'b0;
        s.rw      = rw;
        s.timeout = timeout;
        s.ok      = ok;
        return s;
    endfunction

endpackage

// File: rtl/global_constants.sv
// rtl/global_constants.sv - project-wide constants for the register bus
`ifndef GLOBAL_CONSTANTS_SV
`define GLOBAL_CONSTANTS_SV

`define RB_STATUS_OK_BIT      0
`define RB_STATUS_TIMEOUT_BIT 1
`define NOS_BUS_REQUESTERS    2

`endif

// File: rtl/rr_arbiter_pick.sv
// rtl/rr_arbiter_pick.sv - combinational round-robin winner selection
//
// Ports:
//   req   in  N      request vector
//   ptr   in  IDX_W  index with highest priority this round
//   idx   out IDX_W  first requesting index at or after ptr (modulo N)
//   valid out 1      any request present
module rr_arbiter_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester at or
    // after ptr is the last one written and therefore wins.
    always_comb begin
        idx   = '0;
        cand  = '0;
        valid = |req;
        for (int off = N - 1; off >= 0; off--) begin
            cand = IDX_W'((int'(ptr) + off) % N);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin arbiter for the shared register bus
//
// Optional feature macro: RB_TIMEOUT_EN (abort S_WAIT_ACK after
// TIMEOUT_CYCLES cycles without bus_ack).
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   req/req_RW            per-requester request level and direction (1=write)
//   req_addr/req_data     flattened per-requester address and write data
//   grant                 one-hot current owner
//   done                  one-cycle completion pulse to the owner
//   rd_data/status        read data and status word of the last transaction
//   bus_addr/bus_wdata/bus_RW/bus_strobe  register bus request side
//   bus_ack/bus_rdata     register bus response side
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int NOS_REQ        = 2,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NOS_REQ-1:0]        req,
    input  logic [NOS_REQ-1:0]        req_RW,
    input  logic [NOS_REQ*ADDR_W-1:0] req_addr,
    input  logic [NOS_REQ*DATA_W-1:0] req_data,
    output logic [NOS_REQ-1:0]        grant,
    output logic [NOS_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rd_data,
    output logic [31:0]               status,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_wdata,
    output logic                      bus_RW,
    output logic                      bus_strobe,
    input  logic                      bus_ack,
    input  logic [DATA_W-1:0]         bus_rdata
);

    localparam int IDX_W = (NOS_REQ > 1) ? $clog2(NOS_REQ) : 1;

    if (NOS_REQ < 2 || NOS_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("reg_bus_arbiter: parameter out of range");
    end

    reg_bus_state_t   state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [15:0]      txn_cnt;
    rb_status_t       status_q;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    logic [ADDR_W-1:0] addr_arr [NOS_REQ];
    logic [DATA_W-1:0] data_arr [NOS_REQ];

    for (genvar i = 0; i < NOS_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    assign status = status_q;

    rr_arbiter_pick #(
        .N     (NOS_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef RB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            win_idx    <= '0;
            txn_cnt    <= '0;
            status_q   <= '0;
            rd_data    <= '0;
            grant      <= '0;
            done       <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_RW     <= 1'b0;
            bus_strobe <= 1'b0;
`ifdef RB_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            done       <= '0;
            bus_strobe <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Owner's request fields are captured only here; later
                    // changes on req_* have no effect on this transaction.
                    if (pick_valid) begin
                        win_idx    <= pick_idx;
                        bus_addr   <= addr_arr[pick_idx];
                        bus_wdata  <= data_arr[pick_idx];
                        bus_RW     <= req_RW[pick_idx];
                        grant      <= NOS_REQ'(1) << pick_idx;
                        bus_strobe <= 1'b1;
                        state      <= S_STROBE;
                    end
                end
                S_STROBE: begin
`ifdef RB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // Status carries the post-increment count so it matches
                    // the counter value once S_DONE has updated it.
                    if (bus_ack) begin
                        rd_data       <= bus_RW ? '0 : bus_rdata;
                        status_q      <= rb_make_status(1'b1, 1'b0, bus_RW, 3'(win_idx),
                                                        8'(bus_addr), txn_cnt + 16'd1);
                        done[win_idx] <= 1'b1;
                        state         <= S_DONE;
                    end
`ifdef RB_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        rd_data       <= '0;
                        status_q      <= rb_make_status(1'b0, 1'b1, bus_RW, 3'(win_idx),
                                                        8'(bus_addr), txn_cnt + 16'd1);
                        done[win_idx] <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    grant   <= '0;
                    ptr     <= (win_idx == IDX_W'(NOS_REQ - 1)) ? '0 : win_idx + 1'b1;
                    txn_cnt <= txn_cnt + 16'd1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
